lfsr_sequence_checker: RTL and testbench
========================================

Name: lfsr_sequence_checker

Overview:
- Receiving end of the game's pseudo-random sequence path. The 16-bit LFSR generator produces the pattern shown to the player; this block regenerates the same sequence from the same seed and checks the player's button presses against it, symbol by symbol.
- Each press has a timeout measured in ticks from the 1 ms timer.
- Result is reported to the game controller as a one-cycle Match or Fail pulse.

Parameters:
- MAX_LEN, 16, maximum sequence length accepted; Len is clamped to this.
- TIMEOUT_MS, 2000, number of Tick pulses allowed between presses before a timeout fail.
- TW, 12, width of the tick counter; must satisfy 2^TW > TIMEOUT_MS.

Ports:
- Clk  in  1  system clock, rising-edge.
- Rst  in  1  asynchronous, active-low reset.
- Start  in  1  one-cycle request to begin a checking round.
- Seed  in  16  LFSR seed; the same value was given to the generator.
- Len  in  5  number of symbols to check.
- Tick  in  1  one-cycle 1 ms strobe from the timer.
- Btn_valid  in  1  one-cycle strobe marking a player press.
- Btn  in  2  symbol pressed (four buttons).
- Busy  out  1  high while a round is in progress.
- Match  out  1  one-cycle pulse: whole sequence entered correctly.
- Fail  out  1  one-cycle pulse: wrong symbol, or timeout.
- Timed_out  out  1  sticky; set together with a timeout Fail, cleared on the next accepted Start.
- Count  out  5  number of correct symbols entered in the current round.
- Expected  out  2  symbol currently awaited; equals LFSR[1:0].

Behaviour:
- Reset (Rst=0, asynchronous): the following values apply.
  - State=IDLE; LFSR=16'hFFFF.
  - Busy, Match, Fail, Timed_out all 0; Count=0; tick counter=0.
- LFSR update, applied only on a correct press: fb=L[15].
  - L[0]<=fb; L[1]<=L[0]; L[2]<=L[1]^fb; L[3]<=L[2]^fb; L[4]<=L[3]; L[5]<=L[4]^fb.
  - L[n]<=L[n-1] for n=6..15.
  - This is the generator's polynomial, so the checker's sequence matches the generator's step for step.
- FSM has two states, IDLE and CHECK.
- IDLE:
  - Start=1 does all of the following on that edge, then goes to CHECK:
    - LFSR<=Seed, or 16'hFFFF if Seed==0.
    - Latched length<=Len, clamped to the range 1..MAX_LEN; Len=0 gives 1.
    - Count<=0, tick counter<=0, Timed_out<=0, Busy<=1.
  - Btn_valid and Tick are ignored in IDLE.
- CHECK, priority order:
  - Btn_valid=1 and Btn==LFSR[1:0]:
    - LFSR steps, Count increments, tick counter clears.
    - If Count+1 == latched length: Match=1 for one cycle, Busy<=0, go to IDLE.
  - Btn_valid=1 and Btn!=LFSR[1:0]:
    - Fail=1 for one cycle, Busy<=0, go to IDLE.
    - LFSR and Count hold their values for debug.
  - Else Tick=1:
    - Tick counter increments.
    - If the new value equals TIMEOUT_MS: Fail=1, Timed_out<=1, Busy<=0, go to IDLE.
- Latency: Match/Fail are asserted in the cycle after the deciding Btn_valid or Tick edge (registered outputs).
- Simultaneous events:
  - A press and a terminal Tick in the same cycle: the press wins and the timeout is not taken.
  - Start while in CHECK is ignored; a round cannot be restarted mid-round.
  - Start arriving in the same cycle as a Match/Fail pulse is accepted normally, because the FSM is already back in IDLE.
- Match and Fail are never high together.
- Expected is combinational from the LFSR register; it is valid in both states.
- Reset asserted mid-round aborts immediately: no Match/Fail pulse, all outputs take their reset values.

Test Plan:
- Reset, then Start with Seed=16'h0001, Len=3 -> Busy=1, Expected=1. Press 1 -> Expected=2, Count=1. Press 2 -> Expected=0. Press 0 -> Match pulse for 1 cycle, Busy=0, Count=3.
- Seed=16'hFFFF, Len=4, press 3,3,3,3 -> LFSR passes through FFD3, FF8B, FF3B; Match after the 4th press.
- Seed=16'h0001, Len=3, press 1 then 3 -> Fail pulse, Timed_out=0, Count=1, Busy=0.
- Start with TIMEOUT_MS=5, then 5 Ticks with no press -> Fail on the 5th Tick, Timed_out=1. A following Start clears Timed_out.
- 4 Ticks, then a correct press together with the 5th Tick -> no Fail; tick counter cleared. 5 further Ticks are needed to time out.
- Edge cases:
  - Seed=0 -> LFSR loads FFFF, Expected=3.
  - Len=0 -> one correct press gives Match.
  - Start pulsed during CHECK -> no effect.
  - Rst dropped mid-round -> Busy=0 asynchronously, no pulse.

Source files
------------

// File: rtl/lfsr_sequence_checker.sv
// LFSR sequence checker: regenerates the game's 16-bit LFSR sequence
// and checks player presses against it, with a per-press tick timeout.
module lfsr_sequence_checker #(
  parameter int MAX_LEN    = 16,
  parameter int TIMEOUT_MS = 2000,
  parameter int TW         = 12
) (
  input  logic        Clk,
  input  logic        Rst,
  input  logic        Start,
  input  logic [15:0] Seed,
  input  logic [4:0]  Len,
  input  logic        Tick,
  input  logic        Btn_valid,
  input  logic [1:0]  Btn,
  output logic        Busy,
  output logic        Match,
  output logic        Fail,
  output logic        Timed_out,
  output logic [4:0]  Count,
  output logic [1:0]  Expected
);

  typedef enum logic {
    IDLE  = 1'b0,
    CHECK = 1'b1
  } state_e;

  localparam logic [4:0]    MAXL = 5'(MAX_LEN);
  localparam logic [TW-1:0] TOUT = TW'(TIMEOUT_MS);

  state_e        state_q, state_d;
  logic [15:0]   lfsr_q, lfsr_d;
  logic [4:0]    len_q, len_d;
  logic [4:0]    cnt_q, cnt_d;
  logic [TW-1:0] tick_q, tick_d;
  logic          busy_q, busy_d;
  logic          match_q, match_d;
  logic          fail_q, fail_d;
  logic          tout_q, tout_d;

  logic          hit;
  logic          miss;
  logic          tmr;
  logic [4:0]    len_c;
  logic [4:0]    cnt_inc;
  logic [TW-1:0] tick_inc;

  // One generator step: shift left, feedback into bits 0, 2, 3, 5.
  function automatic logic [15:0] lfsr_step(input logic [15:0] l);
    logic fb;
    logic [15:0] n;
    fb   = l[15];
    n    = {l[14:0], fb};
    n[2] = l[1] ^ fb;
    n[3] = l[2] ^ fb;
    n[5] = l[4] ^ fb;
    return n;
  endfunction

  // Event decode and clamped length for the current cycle.
  always_comb begin
    hit      = Btn_valid && (Btn == lfsr_q[1:0]);
    miss     = Btn_valid && (Btn != lfsr_q[1:0]);
    tmr      = !Btn_valid && Tick;
    cnt_inc  = cnt_q + 5'd1;
    tick_inc = tick_q + 1'b1;
    len_c    = Len;
    if (Len == 5'd0)
      len_c = 5'd1;
    else if (Len > MAXL)
      len_c = MAXL;
  end

  // State and datapath registers; outputs are registered pulses.
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      state_q <= IDLE;
      lfsr_q  <= 16'hFFFF;
      len_q   <= 5'd1;
      cnt_q   <= 5'd0;
      tick_q  <= '0;
      busy_q  <= 1'b0;
      match_q <= 1'b0;
      fail_q  <= 1'b0;
      tout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      lfsr_q  <= lfsr_d;
      len_q   <= len_d;
      cnt_q   <= cnt_d;
      tick_q  <= tick_d;
      busy_q  <= busy_d;
      match_q <= match_d;
      fail_q  <= fail_d;
      tout_q  <= tout_d;
    end
  end

  // Next state: start a round in IDLE, press/timeout decisions in CHECK.
  always_comb begin
    state_d = state_q;
    lfsr_d  = lfsr_q;
    len_d   = len_q;
    cnt_d   = cnt_q;
    tick_d  = tick_q;
    busy_d  = busy_q;
    tout_d  = tout_q;
    match_d = 1'b0;
    fail_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (Start) begin
          lfsr_d  = (Seed == 16'h0000) ? 16'hFFFF : Seed;
          len_d   = len_c;
          cnt_d   = 5'd0;
          tick_d  = '0;
          tout_d  = 1'b0;
          busy_d  = 1'b1;
          state_d = CHECK;
        end
      end
      CHECK: begin
        unique case (1'b1)
          hit: begin
            lfsr_d = lfsr_step(lfsr_q);
            cnt_d  = cnt_inc;
            tick_d = '0;
            if (cnt_inc == len_q) begin
              match_d = 1'b1;
              busy_d  = 1'b0;
              state_d = IDLE;
            end
          end
          miss: begin
            fail_d  = 1'b1;
            busy_d  = 1'b0;
            state_d = IDLE;
          end
          tmr: begin
            tick_d = tick_inc;
            if (tick_inc == TOUT) begin
              fail_d  = 1'b1;
              tout_d  = 1'b1;
              busy_d  = 1'b0;
              state_d = IDLE;
            end
          end
          default: ;
        endcase
      end
      default: state_d = IDLE;
    endcase
  end

  // Output mapping from registered state.
  always_comb begin
    Busy      = busy_q;
    Match     = match_q;
    Fail      = fail_q;
    Timed_out = tout_q;
    Count     = cnt_q;
    Expected  = lfsr_q[1:0];
  end

endmodule

// File: tb/tb_lfsr_sequence_checker.sv
// Bench for lfsr_sequence_checker: directed plan plus randomized rounds
// checked every cycle against a round-level reference model.
module tb_lfsr_sequence_checker;

  localparam int TO = 5;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [15:0] seed;
  logic [4:0]  len;
  logic        tick;
  logic        bv;
  logic [1:0]  btn;
  logic        busy;
  logic        match;
  logic        fail;
  logic        tout;
  logic [4:0]  count;
  logic [1:0]  expd;

  int checks;
  int failures;

  bit          m_active;
  bit          m_to;
  bit          m_match;
  bit          m_fail;
  int          m_len;
  int          m_cnt;
  int          m_ticks;
  logic [15:0] m_lfsr;

  lfsr_sequence_checker #(
    .MAX_LEN(16),
    .TIMEOUT_MS(TO),
    .TW(12)
  ) dut (
    .Clk(clk),
    .Rst(rst_n),
    .Start(start),
    .Seed(seed),
    .Len(len),
    .Tick(tick),
    .Btn_valid(bv),
    .Btn(btn),
    .Busy(busy),
    .Match(match),
    .Fail(fail),
    .Timed_out(tout),
    .Count(count),
    .Expected(expd)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Polynomial x^16+x^5+x^3+x^2+1 as a Galois multiply-by-x.
  function automatic logic [15:0] poly_next(input logic [15:0] l);
    logic [16:0] p;
    p = {1'b0, l} << 1;
    if (p[16]) p = p ^ 17'h1002D;
    return p[15:0];
  endfunction

  function automatic int clamp_len(input int l);
    if (l == 0) return 1;
    if (l > 16) return 16;
    return l;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_active = 0;
    m_to     = 0;
    m_match  = 0;
    m_fail   = 0;
    m_cnt    = 0;
    m_ticks  = 0;
    m_len    = 1;
    m_lfsr   = 16'hFFFF;
  endtask

  task automatic check_all(input string where);
    chk({where, ".busy"}, {31'b0, busy}, {31'b0, m_active});
    chk({where, ".match"}, {31'b0, match}, {31'b0, m_match});
    chk({where, ".fail"}, {31'b0, fail}, {31'b0, m_fail});
    chk({where, ".tout"}, {31'b0, tout}, {31'b0, m_to});
    chk({where, ".count"}, {27'b0, count}, m_cnt);
    chk({where, ".expected"}, {30'b0, expd}, {30'b0, m_lfsr[1:0]});
  endtask

  // Drive one cycle of inputs, advance the model, check after the edge.
  task automatic cyc(input bit st, input logic [15:0] sd,
                     input logic [4:0] ln, input bit tk,
                     input bit v, input logic [1:0] b,
                     input string where);
    @(negedge clk);
    start = st;
    seed  = sd;
    len   = ln;
    tick  = tk;
    bv    = v;
    btn   = b;
    m_match = 0;
    m_fail  = 0;
    if (!m_active) begin
      if (st) begin
        m_lfsr   = (sd == 16'h0) ? 16'hFFFF : sd;
        m_len    = clamp_len(int'(ln));
        m_cnt    = 0;
        m_ticks  = 0;
        m_to     = 0;
        m_active = 1;
      end
    end else if (v) begin
      if (b == m_lfsr[1:0]) begin
        m_lfsr  = poly_next(m_lfsr);
        m_cnt   = m_cnt + 1;
        m_ticks = 0;
        if (m_cnt == m_len) begin
          m_match  = 1;
          m_active = 0;
        end
      end else begin
        m_fail   = 1;
        m_active = 0;
      end
    end else if (tk) begin
      m_ticks = m_ticks + 1;
      if (m_ticks == TO) begin
        m_fail   = 1;
        m_to     = 1;
        m_active = 0;
      end
    end
    @(posedge clk);
    #1;
    check_all(where);
  endtask

  task automatic idle(input string where);
    cyc(0, 16'h0, 5'd0, 0, 0, 2'd0, where);
  endtask

  task automatic press(input logic [1:0] b, input string where);
    cyc(0, 16'h0, 5'd0, 0, 1, b, where);
  endtask

  task automatic tk(input string where);
    cyc(0, 16'h0, 5'd0, 1, 0, 2'd0, where);
  endtask

  initial begin
    logic [15:0] rs;
    logic [4:0]  rl;
    int          r;
    int          guard;
    checks   = 0;
    failures = 0;
    rst_n = 1'b0;
    start = 0;
    seed  = '0;
    len   = '0;
    tick  = 0;
    bv    = 0;
    btn   = '0;
    model_reset();
    @(negedge clk);
    @(negedge clk);
    check_all("reset");
    rst_n = 1'b1;
    idle("post_reset");

    // Basic round, seed 1, length 3.
    cyc(1, 16'h0001, 5'd3, 0, 0, 2'd0, "s1_start");
    chk("s1_exp1", {30'b0, expd}, 32'd1);
    press(2'd1, "s1_p1");
    chk("s1_exp2", {30'b0, expd}, 32'd2);
    press(2'd2, "s1_p2");
    press(2'd0, "s1_p3");
    chk("s1_match", {31'b0, match}, 32'd1);
    chk("s1_count3", {27'b0, count}, 32'd3);
    idle("s1_after");
    chk("s1_pulse1cyc", {31'b0, match}, 32'd0);

    // Seed FFFF, all-3 sequence through FFD3, FF8B, FF3B.
    cyc(1, 16'hFFFF, 5'd4, 0, 0, 2'd0, "s2_start");
    press(2'd3, "s2_p1");
    chk("s2_l1", {16'b0, dut.lfsr_q}, 32'hFFD3);
    press(2'd3, "s2_p2");
    chk("s2_l2", {16'b0, dut.lfsr_q}, 32'hFF8B);
    press(2'd3, "s2_p3");
    chk("s2_l3", {16'b0, dut.lfsr_q}, 32'hFF3B);
    press(2'd3, "s2_p4");
    idle("s2_after");

    // Wrong symbol.
    cyc(1, 16'h0001, 5'd3, 0, 0, 2'd0, "s3_start");
    press(2'd1, "s3_p1");
    press(2'd3, "s3_wrong");
    chk("s3_fail", {31'b0, fail}, 32'd1);
    idle("s3_after");

    // Timeout after TO ticks, then Start clears Timed_out.
    cyc(1, 16'h0001, 5'd5, 0, 0, 2'd0, "s4_start");
    repeat (TO) tk("s4_tick");
    chk("s4_tout", {31'b0, tout}, 32'd1);
    idle("s4_after");
    cyc(1, 16'h0001, 5'd5, 0, 0, 2'd0, "s4_restart");

    // Press together with terminal tick wins and clears the counter.
    repeat (TO - 1) tk("s5_tick");
    cyc(0, 16'h0, 5'd0, 1, 1, 2'd1, "s5_press_tick");
    repeat (TO - 1) tk("s5_tick2");
    chk("s5_no_fail", {31'b0, fail}, 32'd0);
    tk("s5_final_tick");
    idle("s5_after");

    // Seed 0, Len 0, Start during CHECK.
    cyc(1, 16'h0000, 5'd0, 0, 0, 2'd0, "e_seed0");
    chk("e_seed0_exp", {30'b0, expd}, 32'd3);
    press(2'd3, "e_len0_match");
    cyc(1, 16'h0001, 5'd2, 0, 0, 2'd0, "e_start_a");
    cyc(1, 16'hFFFF, 5'd9, 0, 0, 2'd0, "e_start_mid");
    press(2'd1, "e_mid_p1");
    press(2'd2, "e_mid_p2");

    // Reset mid-round.
    cyc(1, 16'h1234, 5'd8, 0, 0, 2'd0, "e_rst_start");
    press(2'd0, "e_rst_p1");
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    check_all("e_rst_async");
    @(negedge clk);
    rst_n = 1'b1;
    idle("e_rst_after");

    // Randomized rounds.
    repeat (60) begin
      rs = ($urandom_range(0, 4) == 0) ? 16'h0 : 16'($urandom);
      rl = 5'($urandom_range(0, 20));
      cyc(1, rs, rl, 0, 0, 2'd0, "rnd_start");
      guard = 0;
      while (m_active && guard < 80) begin
        guard++;
        r = $urandom_range(0, 19);
        if (r < 12)
          cyc(0, 16'h0, 5'd0, bit'($urandom_range(0, 1)), 1,
              m_lfsr[1:0], "rnd_hit");
        else if (r == 12)
          cyc(0, 16'h0, 5'd0, 0, 1,
              m_lfsr[1:0] ^ 2'($urandom_range(1, 3)), "rnd_miss");
        else if (r < 18)
          tk("rnd_tick");
        else
          cyc(1, 16'($urandom), 5'($urandom), 0, 0, 2'd0, "rnd_start_mid");
      end
      if ($urandom_range(0, 1) == 1) idle("rnd_gap");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
